// File: rtl/miriscv_lsu_ctrl.sv
// Load/store sequencer: turns one decoded load/store into a single req/gnt/rvalid bus
// transaction, formats store data and byte enables, and aligns/extends load data.
module miriscv_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_kill_i,
  output logic        lsu_stall_o,
  output logic        lsu_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_buserr_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam logic [2:0] MEM_ACCESS_WORD  = 3'd0;
  localparam logic [2:0] MEM_ACCESS_HALF  = 3'd1;
  localparam logic [2:0] MEM_ACCESS_BYTE  = 3'd2;
  localparam logic [2:0] MEM_ACCESS_UHALF = 3'd3;
  localparam logic [2:0] MEM_ACCESS_UBYTE = 3'd4;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] waddr_q, waddr_d;
  logic        req_q, req_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        buserr_q, buserr_d;

  logic        accept;
  logic        misalign_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] load_shift;
  logic [31:0] load_ext;
  logic        timeout;
  logic        kill_now;

  // Request decode: alignment check, byte enables and store-data replication.
  always_comb begin
    misalign_in = 1'b0;
    be_in       = 4'b1111;
    wdata_in    = lsu_wdata_i;
    case (lsu_size_i)
      MEM_ACCESS_WORD: begin
        misalign_in = (lsu_addr_i[1:0] != 2'b00);
      end
      MEM_ACCESS_HALF, MEM_ACCESS_UHALF: begin
        misalign_in = lsu_addr_i[0];
        be_in       = 4'b0011 << lsu_addr_i[1:0];
        wdata_in    = {2{lsu_wdata_i[15:0]}};
      end
      MEM_ACCESS_BYTE, MEM_ACCESS_UBYTE: begin
        be_in    = 4'b0001 << lsu_addr_i[1:0];
        wdata_in = {4{lsu_wdata_i[7:0]}};
      end
      default: begin
        misalign_in = 1'b1;
      end
    endcase
  end

  // Load data alignment and extension; stores report zero.
  always_comb begin
    load_shift = data_rdata_i >> {off_q, 3'b000};
    load_ext   = load_shift;
    case (size_q)
      MEM_ACCESS_HALF:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      MEM_ACCESS_UHALF: load_ext = {16'h0000, load_shift[15:0]};
      MEM_ACCESS_BYTE:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      MEM_ACCESS_UBYTE: load_ext = {24'h000000, load_shift[7:0]};
      default:          load_ext = load_shift;
    endcase
    if (we_q) begin
      load_ext = 32'h0;
    end
  end

  assign accept   = lsu_req_i & ~lsu_kill_i;
  assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q >= TIMEOUT_LAST);
  assign kill_now = kill_q | lsu_kill_i;

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    size_d         = size_q;
    off_d          = off_q;
    waddr_d        = waddr_q;
    req_d          = req_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    kill_d         = kill_q;
    rdata_d        = rdata_q;
    misalign_d     = misalign_q;
    buserr_d       = buserr_q;
    lsu_stall_o    = 1'b0;
    lsu_valid_o    = 1'b0;
    lsu_rdata_o    = 32'h0;
    lsu_misalign_o = 1'b0;
    lsu_buserr_o   = 1'b0;

    case (state_q)
      IDLE: begin
        lsu_stall_o = accept;
        if (accept) begin
          we_d       = lsu_we_i;
          size_d     = lsu_size_i;
          off_d      = lsu_addr_i[1:0];
          kill_d     = 1'b0;
          rdata_d    = 32'h0;
          buserr_d   = 1'b0;
          misalign_d = misalign_in;
          if (misalign_in) begin
            state_d = DONE;
          end else begin
            waddr_d = lsu_addr_i[31:2];
            be_d    = be_in;
            wdata_d = wdata_in;
            req_d   = 1'b1;
            cnt_d   = 32'h0;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        lsu_stall_o = 1'b1;
        if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
        // A grant commits the bus transaction, so a same-cycle kill only defers.
        if (data_gnt_i) begin
          req_d   = 1'b0;
          kill_d  = lsu_kill_i;
          state_d = RESP;
        end else if (lsu_kill_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (timeout) begin
          req_d    = 1'b0;
          buserr_d = 1'b1;
          rdata_d  = 32'h0;
          state_d  = DONE;
        end
      end

      RESP: begin
        lsu_stall_o = 1'b1;
        if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
        if (lsu_kill_i) begin
          kill_d = 1'b1;
        end
        if (data_rvalid_i) begin
          rdata_d = load_ext;
          kill_d  = 1'b0;
          state_d = kill_now ? IDLE : DONE;
        end else if (timeout) begin
          buserr_d = 1'b1;
          rdata_d  = 32'h0;
          kill_d   = 1'b0;
          state_d  = kill_now ? IDLE : DONE;
        end
      end

      DONE: begin
        lsu_valid_o    = 1'b1;
        lsu_rdata_o    = rdata_q;
        lsu_misalign_o = misalign_q;
        lsu_buserr_o   = buserr_q;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      off_q      <= 2'd0;
      waddr_q    <= 30'd0;
      req_q      <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'h0;
      cnt_q      <= 32'h0;
      kill_q     <= 1'b0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      off_q      <= off_d;
      waddr_q    <= waddr_d;
      req_q      <= req_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      buserr_q   <= buserr_d;
    end
  end

  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = {waddr_q, 2'b00};
  assign data_wdata_o = wdata_q;

endmodule
